// File: rtl/alpha_blend_stream_sync_pkg.sv
// Shared definitions for the background/foreground stream aligner in front of the alpha blender.
// Holds the aligner state encoding, the default beat widths and small decode helpers.
package alpha_blend_stream_sync_pkg;

   localparam int BG_W = 30;
   localparam int FG_W = 40;

   typedef enum logic [0:0] {
      ST_SYNC   = 1'b0,
      ST_STREAM = 1'b1
   } sync_state_e;

   // True when exactly one of two markers is set, i.e. the streams disagree on a boundary.
   function automatic logic odd_one(input logic a, input logic b);
      return a ^ b;
   endfunction

endpackage

// File: rtl/alpha_blend_stream_sync_pipe_reg.sv
// Single-stage valid/ready register; accepts a new beat whenever it is empty or being drained.
// Used as the registered output stage of the stream aligner.
module stream_pipe_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);

   logic [W-1:0] data_d, data_q;
   logic         valid_d, valid_q;

   // Upstream may load when the stage is empty or its beat leaves this cycle.
   always_comb begin
      in_ready = ~valid_q | out_ready;
   end

   // Next-state for the held beat.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (in_valid && in_ready) begin
         data_d  = in_data;
         valid_d = 1'b1;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Stage storage.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q  <= {W{1'b0}};
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;

endmodule

// File: rtl/alpha_blend_stream_sync.sv
// Aligns background and foreground Avalon-ST streams on start-of-packet, flushes stale beats
// after a misalignment and hands registered pairs to the blender with frame/resync status.
module alpha_blend_stream_sync
   import alpha_blend_stream_sync_pkg::*;
#(
   parameter int BG_WIDTH  = BG_W,
   parameter int FG_WIDTH  = FG_W,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [BG_WIDTH-1:0]  bg_data,
   input  logic                 bg_startofpacket,
   input  logic                 bg_endofpacket,
   input  logic                 bg_valid,
   output logic                 bg_ready,
   input  logic [FG_WIDTH-1:0]  fg_data,
   input  logic                 fg_startofpacket,
   input  logic                 fg_endofpacket,
   input  logic                 fg_valid,
   output logic                 fg_ready,
   output logic [BG_WIDTH-1:0]  pair_bg_data,
   output logic [FG_WIDTH-1:0]  pair_fg_data,
   output logic                 pair_startofpacket,
   output logic                 pair_endofpacket,
   output logic                 pair_valid,
   input  logic                 pair_ready,
   output logic [CNT_WIDTH-1:0] frame_count,
   output logic [CNT_WIDTH-1:0] resync_count,
   output logic                 misalign
);

   localparam int PAY_W = BG_WIDTH + FG_WIDTH + 2;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   sync_state_e          state_d, state_q;
   logic [CNT_WIDTH-1:0] frame_count_d, frame_count_q;
   logic [CNT_WIDTH-1:0] resync_count_d, resync_count_q;
   logic                 misalign_d, misalign_q;

   logic             both_valid_s;
   logic             pair_req_s;
   logic             sop_clash_s;
   logic             bg_flush_s;
   logic             fg_flush_s;
   logic             out_free_s;
   logic             load_s;
   logic             frame_done_s;
   logic             misalign_det_s;
   logic [PAY_W-1:0] pay_in_s;
   logic [PAY_W-1:0] pay_out_s;

   // Decide whether the current heads may be paired, flushed or signal a boundary clash.
   always_comb begin
      both_valid_s = bg_valid & fg_valid;
      pair_req_s   = 1'b0;
      sop_clash_s  = 1'b0;
      bg_flush_s   = 1'b0;
      fg_flush_s   = 1'b0;
      case (state_q)
         ST_SYNC: begin
            // Non-SOP heads are stale and dropped; SOP heads wait for their partner.
            bg_flush_s = bg_valid & ~bg_startofpacket;
            fg_flush_s = fg_valid & ~fg_startofpacket;
            pair_req_s = both_valid_s & bg_startofpacket & fg_startofpacket;
         end
         ST_STREAM: begin
            if (both_valid_s && (bg_startofpacket || fg_startofpacket)) begin
               sop_clash_s = 1'b1;
            end else begin
               pair_req_s = both_valid_s;
            end
         end
         default: begin
            pair_req_s = 1'b0;
         end
      endcase
   end

   assign pay_in_s = {fg_startofpacket, bg_endofpacket | fg_endofpacket, fg_data, bg_data};

   stream_pipe_reg #(
      .W(PAY_W)
   ) u_out_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_data  (pay_in_s),
      .in_valid (pair_req_s),
      .in_ready (out_free_s),
      .out_data (pay_out_s),
      .out_valid(pair_valid),
      .out_ready(pair_ready)
   );

   // Handshakes, state transitions and status updates driven by the load decision.
   always_comb begin
      load_s         = pair_req_s & out_free_s;
      bg_ready       = reset_n & (load_s | bg_flush_s);
      fg_ready       = reset_n & (load_s | fg_flush_s);
      frame_done_s   = 1'b0;
      misalign_det_s = sop_clash_s;
      state_d        = state_q;
      if (sop_clash_s) begin
         state_d = ST_SYNC;
      end else if (load_s) begin
         if (bg_endofpacket && fg_endofpacket) begin
            frame_done_s = 1'b1;
            state_d      = ST_SYNC;
         end else if (odd_one(bg_endofpacket, fg_endofpacket)) begin
            // A one-sided EOP still ships the beat but the frame is not counted.
            misalign_det_s = 1'b1;
            state_d        = ST_SYNC;
         end else begin
            state_d = ST_STREAM;
         end
      end else begin
         state_d = state_q;
      end

      if (frame_done_s) begin
         frame_count_d = frame_count_q + CNT_ONE;
      end else begin
         frame_count_d = frame_count_q;
      end

      if (misalign_det_s && (resync_count_q != CNT_MAX)) begin
         resync_count_d = resync_count_q + CNT_ONE;
      end else begin
         resync_count_d = resync_count_q;
      end

      misalign_d = misalign_det_s;
   end

   // Aligner state, status counters and the registered misalign pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_SYNC;
         frame_count_q  <= {CNT_WIDTH{1'b0}};
         resync_count_q <= {CNT_WIDTH{1'b0}};
         misalign_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         frame_count_q  <= frame_count_d;
         resync_count_q <= resync_count_d;
         misalign_q     <= misalign_d;
      end
   end

   assign pair_bg_data       = pay_out_s[BG_WIDTH-1:0];
   assign pair_fg_data       = pay_out_s[BG_WIDTH +: FG_WIDTH];
   assign pair_endofpacket   = pay_out_s[PAY_W-2];
   assign pair_startofpacket = pay_out_s[PAY_W-1];
   assign frame_count        = frame_count_q;
   assign resync_count       = resync_count_q;
   assign misalign           = misalign_q;

endmodule

// File: tb/tb_alpha_blend_stream_sync.sv
// Scoreboard bench for alpha_blend_stream_sync: per-stream beat queues feed the DUT and the
// expected pairs are queued as stimulus is built, then compared as pairs are accepted.
module tb_alpha_blend_stream_sync;

   localparam int BW = 30;
   localparam int FW = 40;
   localparam int CW = 8;

   typedef struct packed {
      logic          stale;
      logic          eop;
      logic          sop;
      logic [FW-1:0] data;
   } beat_t;

   typedef logic [BW+FW+1:0] pair_t;

   logic          clk;
   logic          reset_n;
   logic [BW-1:0] bg_data;
   logic          bg_sop, bg_eop, bg_valid, bg_ready;
   logic [FW-1:0] fg_data;
   logic          fg_sop, fg_eop, fg_valid, fg_ready;
   logic [BW-1:0] pair_bg;
   logic [FW-1:0] pair_fg;
   logic          pair_sop, pair_eop, pair_valid, pair_ready;
   logic [CW-1:0] frame_count, resync_count;
   logic          misalign;

   beat_t bg_q[$];
   beat_t fg_q[$];
   pair_t exp_q[$];
   logic  pr_pat[$];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   npairs = 0;
   int   mis_cnt = 0;
   int   stale_bg = 0;
   int   stale_fg = 0;
   int   stall_cnt = 0;
   int   first_acc = -1;
   int   last_acc = -1;
   logic mis_prev = 1'b0;
   logic gap_en = 1'b0;
   logic pr_rand = 1'b0;

   alpha_blend_stream_sync #(
      .BG_WIDTH (BW),
      .FG_WIDTH (FW),
      .CNT_WIDTH(CW)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .bg_data           (bg_data),
      .bg_startofpacket  (bg_sop),
      .bg_endofpacket    (bg_eop),
      .bg_valid          (bg_valid),
      .bg_ready          (bg_ready),
      .fg_data           (fg_data),
      .fg_startofpacket  (fg_sop),
      .fg_endofpacket    (fg_eop),
      .fg_valid          (fg_valid),
      .fg_ready          (fg_ready),
      .pair_bg_data      (pair_bg),
      .pair_fg_data      (pair_fg),
      .pair_startofpacket(pair_sop),
      .pair_endofpacket  (pair_eop),
      .pair_valid        (pair_valid),
      .pair_ready        (pair_ready),
      .frame_count       (frame_count),
      .resync_count      (resync_count),
      .misalign          (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_bg(input logic [BW-1:0] d, input logic s, input logic e, input logic st);
      beat_t b;
      b.data  = {{(FW-BW){1'b0}}, d};
      b.sop   = s;
      b.eop   = e;
      b.stale = st;
      bg_q.push_back(b);
   endtask

   task automatic push_fg(input logic [FW-1:0] d, input logic s, input logic e, input logic st);
      beat_t b;
      b.data  = d;
      b.sop   = s;
      b.eop   = e;
      b.stale = st;
      fg_q.push_back(b);
   endtask

   // Aligned frame on both streams; each beat is expected to emerge as one pair.
   task automatic push_frame(input int n);
      logic [BW-1:0] bd;
      logic [FW-1:0] fd;
      logic          s, e;
      for (int i = 0; i < n; i++) begin
         bd = BW'($urandom);
         fd = {8'($urandom), 32'($urandom)};
         s  = (i == 0);
         e  = (i == n - 1);
         push_bg(bd, s, e, 1'b0);
         push_fg(fd, s, e, 1'b0);
         exp_q.push_back({s, e, fd, bd});
      end
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while ((bg_q.size() != 0 || fg_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
         @(posedge clk);
         n++;
      end
      check_val({tag, "_drained"}, (bg_q.size() == 0 && fg_q.size() == 0 && exp_q.size() == 0), 1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic check_reset_outs(input string tag);
      check_val({tag, "_ctl"}, {pair_valid, pair_sop, pair_eop, misalign, bg_ready, fg_ready}, 0);
      check_val({tag, "_data"}, {pair_fg, pair_bg}, 0);
      check_val({tag, "_cnt"}, {frame_count, resync_count}, 0);
   endtask

   // Source/sink driver: present queue heads and the downstream ready after each edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (bg_q.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
            bg_valid = 1'b1;
            bg_data  = bg_q[0].data[BW-1:0];
            bg_sop   = bg_q[0].sop;
            bg_eop   = bg_q[0].eop;
         end else begin
            bg_valid = 1'b0;
            bg_data  = '0;
            bg_sop   = 1'b0;
            bg_eop   = 1'b0;
         end
         if (fg_q.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
            fg_valid = 1'b1;
            fg_data  = fg_q[0].data;
            fg_sop   = fg_q[0].sop;
            fg_eop   = fg_q[0].eop;
         end else begin
            fg_valid = 1'b0;
            fg_data  = '0;
            fg_sop   = 1'b0;
            fg_eop   = 1'b0;
         end
         if (pr_pat.size() > 0) pair_ready = pr_pat.pop_front();
         else if (pr_rand) pair_ready = 1'($urandom_range(0, 1));
         else pair_ready = 1'b1;
      end
   end

   // Monitor: handshakes seen here complete at the next rising edge.
   initial begin
      beat_t b;
      pair_t obs, e;
      forever begin
         @(negedge clk);
         cyc++;
         if (misalign) begin
            mis_cnt++;
            check_val("misalign_width", mis_prev, 0);
         end
         mis_prev = misalign;
         if (reset_n) begin
            if (bg_valid && bg_ready) begin
               b = bg_q.pop_front();
               if (b.stale) begin
                  stale_bg++;
                  check_val("bg_flush_fg_held", fg_ready, 0);
               end
            end
            if (fg_valid && fg_ready) begin
               b = fg_q.pop_front();
               if (b.stale) begin
                  stale_fg++;
                  check_val("fg_flush_bg_held", bg_ready, 0);
               end
            end
            if (pair_valid) begin
               obs = {pair_sop, pair_eop, pair_fg, pair_bg};
               if (exp_q.size() == 0) begin
                  check_val("unexpected_pair", pair_valid, 0);
               end else if (pair_ready) begin
                  e = exp_q.pop_front();
                  check_val("pair", obs, e);
                  npairs++;
                  if (first_acc < 0) first_acc = cyc;
                  last_acc = cyc;
               end else begin
                  stall_cnt++;
                  check_val("stall_hold", obs, exp_q[0]);
               end
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int base, base_mis, base_sbg, base_sfg, n;
      logic [BW-1:0] a_bd[4];
      logic [FW-1:0] a_fd[2];

      reset_n    = 1'b0;
      bg_valid   = 1'b0; bg_data = '0; bg_sop = 1'b0; bg_eop = 1'b0;
      fg_valid   = 1'b0; fg_data = '0; fg_sop = 1'b0; fg_eop = 1'b0;
      pair_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check_reset_outs("reset");
      @(posedge clk);
      #2 reset_n = 1'b1;

      // Aligned frames at full throughput.
      base = npairs;
      first_acc = -1;
      @(posedge clk);
      for (int f = 0; f < 3; f++) push_frame(4);
      drain("aligned", 200);
      check_val("aligned_pairs", npairs - base, 12);
      check_val("aligned_gapless", last_acc - first_acc, 11);
      check_val("aligned_frames", frame_count, 3);
      check_val("aligned_resync", resync_count, 0);
      check_val("aligned_misalign", mis_cnt, 0);

      // Two stale background beats ahead of a frame, with random source gaps.
      gap_en = 1'b1;
      base_sbg = stale_bg;
      @(posedge clk);
      push_bg(BW'($urandom), 1'b0, 1'b0, 1'b1);
      push_bg(BW'($urandom), 1'b0, 1'b1, 1'b1);
      push_frame(4);
      drain("stale", 400);
      check_val("stale_flushed", stale_bg - base_sbg, 2);
      check_val("stale_misalign", mis_cnt, 0);
      check_val("stale_frames", frame_count, 4);

      // Foreground restarts at beat 2 of a background frame, with random backpressure.
      pr_rand  = 1'b1;
      base_sbg = stale_bg;
      base_mis = mis_cnt;
      @(posedge clk);
      for (int i = 0; i < 4; i++) a_bd[i] = BW'($urandom);
      for (int i = 0; i < 2; i++) a_fd[i] = {8'($urandom), 32'($urandom)};
      push_bg(a_bd[0], 1'b1, 1'b0, 1'b0);
      push_bg(a_bd[1], 1'b0, 1'b0, 1'b0);
      push_bg(a_bd[2], 1'b0, 1'b0, 1'b1);
      push_bg(a_bd[3], 1'b0, 1'b1, 1'b1);
      push_fg(a_fd[0], 1'b1, 1'b0, 1'b0);
      push_fg(a_fd[1], 1'b0, 1'b0, 1'b0);
      exp_q.push_back({1'b1, 1'b0, a_fd[0], a_bd[0]});
      exp_q.push_back({1'b0, 1'b0, a_fd[1], a_bd[1]});
      push_frame(4);
      drain("midsop", 400);
      check_val("midsop_pulses", mis_cnt - base_mis, 1);
      check_val("midsop_resync", resync_count, 1);
      check_val("midsop_flushed", stale_bg - base_sbg, 2);
      check_val("midsop_frames", frame_count, 5);

      // Fixed backpressure pattern during one frame.
      gap_en    = 1'b0;
      pr_rand   = 1'b0;
      stall_cnt = 0;
      base      = npairs;
      @(posedge clk);
      pr_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      push_frame(4);
      drain("bp", 200);
      check_val("bp_pairs", npairs - base, 4);
      check_val("bp_stalled", (stall_cnt >= 2), 1);
      check_val("bp_frames", frame_count, 6);

      // Reset after two beats of a frame, then a fresh frame.
      base = npairs;
      base_mis = mis_cnt;
      @(posedge clk);
      push_frame(4);
      n = 0;
      while (npairs < base + 2 && n < 100) begin
         @(posedge clk);
         n++;
      end
      check_val("rst_two_pairs_seen", npairs - base, 2);
      #2 reset_n = 1'b0;
      exp_q.delete();
      repeat (2) begin
         @(negedge clk);
         #1;
         check_reset_outs("midreset");
      end
      @(posedge clk);
      #2 reset_n = 1'b1;
      base = npairs;
      @(posedge clk);
      push_frame(4);
      drain("postreset", 200);
      check_val("postreset_pairs", npairs - base, 4);
      check_val("postreset_frames", frame_count, 1);
      check_val("postreset_resync", resync_count, 0);
      check_val("postreset_misalign", mis_cnt - base_mis, 0);

      // Single-beat frames until the frame counter wraps to zero.
      @(posedge clk);
      for (int i = 0; i < (1 << CW) - 1; i++) push_frame(1);
      drain("wrap", 3000);
      check_val("frame_wrap", frame_count, 0);

      // Forced misalignments beyond the resync counter range.
      pr_rand  = 1'b1;
      base_mis = mis_cnt;
      base_sfg = stale_fg;
      @(posedge clk);
      for (int i = 0; i < (1 << CW) + 4; i++) begin
         logic [BW-1:0] bd;
         logic [FW-1:0] fd;
         bd = BW'($urandom);
         fd = {8'($urandom), 32'($urandom)};
         push_bg(bd, 1'b1, 1'b0, 1'b0);
         push_fg(fd, 1'b1, 1'b0, 1'b0);
         push_fg({8'($urandom), 32'($urandom)}, 1'b0, 1'b0, 1'b1);
         exp_q.push_back({1'b1, 1'b0, fd, bd});
      end
      push_frame(1);
      drain("sat", 6000);
      check_val("resync_saturated", resync_count, {CW{1'b1}});
      check_val("sat_pulses", mis_cnt - base_mis, (1 << CW) + 4);
      check_val("sat_fg_flushed", stale_fg - base_sfg, (1 << CW) + 4);
      check_val("sat_frames", frame_count, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alpha_blend_stream_sync.md
# alpha_blend_stream_sync

Frame-alignment controller that sits in front of the alpha blender in the video pipeline. It takes the background (30-bit RGB) and foreground (40-bit ARGB) Avalon-ST streams, aligns them on start-of-packet, and discards stale beats after a misalignment. It emits registered, paired beats to the blender with full throughput, and keeps frame and resync counters for software status.

## Interface
Parameters:
- BG_WIDTH, 30, background beat width
- FG_WIDTH, 40, foreground beat width
- CNT_WIDTH, 16, width of frame_count and resync_count

Ports:
- clk  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- bg_data  in  BG_WIDTH  background pixel
- bg_startofpacket, bg_endofpacket, bg_valid  in  1 each  background stream control
- bg_ready  out  1  background beat consumed this cycle
- fg_data  in  FG_WIDTH  foreground pixel
- fg_startofpacket, fg_endofpacket, fg_valid  in  1 each  foreground stream control
- fg_ready  out  1  foreground beat consumed this cycle
- pair_bg_data  out  BG_WIDTH  registered background beat
- pair_fg_data  out  FG_WIDTH  registered foreground beat
- pair_startofpacket, pair_endofpacket  out  1 each  registered packet markers
- pair_valid  out  1  paired beat available
- pair_ready  in  1  blender/downstream accepts the paired beat
- frame_count  out  CNT_WIDTH  frames fully passed; wraps at 2^CNT_WIDTH
- resync_count  out  CNT_WIDTH  misalignments detected; saturates at all-ones
- misalign  out  1  one-cycle pulse per detected misalignment

## Operation
- Reset (reset_n low, asynchronous): state SYNC. All outputs read 0: pair_* and both counters are cleared, and misalign is low. bg_ready and fg_ready are combinational, but they are forced to 0 while in reset.
- The output stage is one register. `load` = both_valid & (~pair_valid | pair_ready) & pairing_allowed. A pair is consumed only on `load`; both ready lines assert together.
- SYNC:
  - The background stream is flushed independently: bg_ready = bg_valid & ~bg_startofpacket. The foreground stream is flushed the same way.
  - A stream whose head beat carries SOP is held.
  - When both heads are SOP and `load` occurs, the pair is loaded and the state goes to STREAM.
  - If both heads are SOP and EOP (single-beat frame), the pair is loaded, frame_count increments, and the state stays SYNC.
- STREAM:
  - Both valid, neither SOP, output free: load the pair.
  - Both EOP: load the pair, frame_count += 1, state goes to SYNC.
  - Both valid and exactly one has SOP: misalignment. Pulse misalign, resync_count += 1, state goes to SYNC. Nothing is consumed this cycle; the SOP beat stays held.
  - Exactly one has EOP on a load: load the pair (with that EOP), pulse misalign, resync_count += 1, state goes to SYNC. frame_count does not increment.
  - Both SOP: misalignment. Treat it as a truncated frame: pulse misalign, resync_count += 1, state goes to SYNC without consuming. The next cycle realigns on these SOPs.
- pair_startofpacket is registered from the foreground SOP of the loaded beat. pair_endofpacket is the OR of both EOPs of the loaded beat.
- Backpressure: while pair_valid & ~pair_ready, no beat is consumed in STREAM. Flushing in SYNC continues regardless of backpressure.

## Timing
- Latency is 1 cycle from `load` to pair_valid. Throughput is 1 pair per cycle when pair_ready is held high.
- pair_* stays stable while pair_valid & ~pair_ready. pair_valid falls the cycle after acceptance unless a new load occurs.
- misalign is registered: it is high for exactly one cycle, the cycle after detection.
- Counter updates are visible the cycle after the triggering event.
- Reset asserted mid-frame: output beats are dropped immediately. After release the block is in SYNC and waits for fresh SOPs.
- Simultaneous events:
  - A flush of one stream and a hold of the other in the same cycle is legal.
  - A misalignment and a backpressure stall in the same cycle still count the misalignment once.

## Structure
- A shared video stream package holds the state enumeration (SYNC, STREAM) and the width constants 30/40.
- One natural sub-module: `stream_pipe_reg`, a valid/ready single-stage register that is reused for the output stage.
- The FSM and counters stay in the top level.

## Test plan
- Aligned frames: 3 frames of 4 beats each, both streams, pair_ready=1 -> 12 pairs, SOP on beats 0/4/8, EOP on 3/7/11, frame_count=3, resync_count=0, no idle cycles after the first load.
- Stale background: bg sends 2 non-SOP beats, then a frame; fg sends only a frame -> both stale beats flushed (bg_ready high, fg_ready low), first pair has SOP, misalign never pulses.
- Mid-frame SOP on fg at beat 2 of a 4-beat bg frame -> misalign pulses once, resync_count=1, the remaining bg beats are flushed, and the next pair carries both SOPs.
- Backpressure: pair_ready toggles 1,0,0,1 during a 4-beat frame -> data held stable during stalls, no duplicated or lost beats, frame_count=1.
- Reset mid-frame after 2 beats, then a full 4-beat frame -> all outputs 0 during reset, counters 0, exactly 4 pairs emitted after release.
- Counter wrap: 65536 single-beat frames -> frame_count wraps to 0; 65540 forced misalignments -> resync_count holds 0xFFFF.
